replacement_master_controller: RTL

//  Master side of the ReplacementAlgorithmInterface: fully associative tag lookup/allocate unit for a cache.

---
 rtl/replacement_master_controller_pkg.sv | 23 ++
 rtl/replacement_master_controller_if.sv | 43 ++++
 rtl/replacement_master_controller_tag_match_unit.sv | 35 +++
 rtl/replacement_master_controller.sv | 138 +++++++++++++
 4 files changed

// File: rtl/replacement_master_controller_pkg.sv
// Shared types and sizing helpers for the replacement master controller and its
// replacement-algorithm slave interface.
package replacement_master_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        FILL    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    // Line index width used by both master and replacement slaves.
    function automatic int counter_width(input int lines);
        if (lines <= 4)        return 2;
        else if (lines <= 8)   return 3;
        else if (lines <= 16)  return 4;
        else if (lines <= 32)  return 5;
        else if (lines <= 64)  return 6;
        else if (lines <= 128) return 7;
        else                   return 8;
    endfunction

endpackage

// File: rtl/replacement_master_controller_if.sv
// Request/response bus from the cache controller, and the ReplacementAlgorithmInterface
// between this master and a replacement-algorithm slave.
interface replacement_request_if #(
    parameter int TAG_WIDTH     = 8,
    parameter int COUNTER_WIDTH = 2
);
    logic                     requestValid;
    logic [TAG_WIDTH-1:0]     requestTag;
    logic                     requestReady;
    logic                     invalidate;
    logic                     responseValid;
    logic                     responseHit;
    logic [COUNTER_WIDTH-1:0] responseCacheLine;

    modport master (
        output requestValid, requestTag, invalidate,
        input  requestReady, responseValid, responseHit, responseCacheLine
    );

    modport slave (
        input  requestValid, requestTag, invalidate,
        output requestReady, responseValid, responseHit, responseCacheLine
    );
endinterface

interface replacement_algorithm_if #(
    parameter int COUNTER_WIDTH = 2
);
    logic [COUNTER_WIDTH-1:0] lastAccessedCacheLine;
    logic                     enable;
    logic                     replacementReset;
    logic [COUNTER_WIDTH-1:0] replacementCacheLine;

    modport master (
        output lastAccessedCacheLine, enable, replacementReset,
        input  replacementCacheLine
    );

    modport slave (
        input  lastAccessedCacheLine, enable, replacementReset,
        output replacementCacheLine
    );
endinterface

// File: rtl/replacement_master_controller_tag_match_unit.sv
// Combinational tag compare across all lines plus lowest-invalid-line search;
// both encoders give priority to the lowest index.
module tag_match_unit #(
    parameter int NUMBER_OF_CACHE_LINES = 4,
    parameter int COUNTER_WIDTH         = 2,
    parameter int TAG_WIDTH             = 8
) (
    input  logic [NUMBER_OF_CACHE_LINES-1:0][TAG_WIDTH-1:0] i_tags,
    input  logic [NUMBER_OF_CACHE_LINES-1:0]                i_valid,
    input  logic [TAG_WIDTH-1:0]                            i_tag,
    output logic                                            o_hit,
    output logic [COUNTER_WIDTH-1:0]                        o_hit_index,
    output logic                                            o_any_invalid,
    output logic [COUNTER_WIDTH-1:0]                        o_invalid_index
);

    // Walking downward lets the lowest matching index overwrite higher ones.
    always_comb begin
        o_hit           = 1'b0;
        o_hit_index     = '0;
        o_any_invalid   = 1'b0;
        o_invalid_index = '0;
        for (int i = NUMBER_OF_CACHE_LINES - 1; i >= 0; i--) begin
            if (i_valid[i] && (i_tags[i] == i_tag)) begin
                o_hit       = 1'b1;
                o_hit_index = COUNTER_WIDTH'(i);
            end
            if (!i_valid[i]) begin
                o_any_invalid   = 1'b1;
                o_invalid_index = COUNTER_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/replacement_master_controller.sv
// Fully associative tag lookup/allocate unit; master of the replacement-algorithm
// interface, asking the slave for a victim only when every line is valid.
module replacement_master_controller
    import replacement_master_pkg::*;
#(
    parameter int NUMBER_OF_CACHE_LINES = 4,
    parameter int COUNTER_WIDTH         = counter_width(NUMBER_OF_CACHE_LINES),
    parameter int TAG_WIDTH             = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    replacement_request_if.slave    req_bus,
    replacement_algorithm_if.master repl_bus
);

    localparam int N = NUMBER_OF_CACHE_LINES;

    state_t                          r_state;
    logic [N-1:0][TAG_WIDTH-1:0]     r_tags;
    logic [N-1:0]                    r_valid;
    logic [TAG_WIDTH-1:0]            r_tag;
    logic [COUNTER_WIDTH-1:0]        r_index;
    logic [COUNTER_WIDTH-1:0]        r_resp_line;
    logic [COUNTER_WIDTH-1:0]        r_last_line;
    logic                            r_resp_valid;
    logic                            r_resp_hit;
    logic                            r_enable;
    logic                            r_flush_pending;

    logic                            w_hit;
    logic [COUNTER_WIDTH-1:0]        w_hit_index;
    logic                            w_any_invalid;
    logic [COUNTER_WIDTH-1:0]        w_invalid_index;
    logic [COUNTER_WIDTH-1:0]        w_victim;
    logic                            w_flush;

    tag_match_unit #(
        .NUMBER_OF_CACHE_LINES (N),
        .COUNTER_WIDTH         (COUNTER_WIDTH),
        .TAG_WIDTH             (TAG_WIDTH)
    ) u_tag_match (
        .i_tags          (r_tags),
        .i_valid         (r_valid),
        .i_tag           (r_tag),
        .o_hit           (w_hit),
        .o_hit_index     (w_hit_index),
        .o_any_invalid   (w_any_invalid),
        .o_invalid_index (w_invalid_index)
    );

    assign w_flush = (r_state == IDLE) && (r_flush_pending || req_bus.invalidate);

    // The slave's proposal is only trusted when the set is full and in range.
    always_comb begin
        w_victim = repl_bus.replacementCacheLine;
        if (w_any_invalid) begin
            w_victim = w_invalid_index;
        end else if (32'(repl_bus.replacementCacheLine) >= N) begin
            w_victim = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_tags          <= '0;
            r_valid         <= '0;
            r_tag           <= '0;
            r_index         <= '0;
            r_resp_line     <= '0;
            r_last_line     <= '0;
            r_resp_valid    <= 1'b0;
            r_resp_hit      <= 1'b0;
            r_enable        <= 1'b0;
            r_flush_pending <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_enable     <= 1'b0;
            if (req_bus.invalidate && (r_state != IDLE)) begin
                r_flush_pending <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_flush) begin
                        r_valid         <= '0;
                        r_flush_pending <= 1'b0;
                    end else if (req_bus.requestValid) begin
                        r_tag   <= req_bus.requestTag;
                        r_state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (w_hit) begin
                        r_index      <= w_hit_index;
                        r_resp_hit   <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_enable     <= 1'b1;
                        r_resp_line  <= w_hit_index;
                        r_last_line  <= w_hit_index;
                        r_state      <= RESPOND;
                    end else begin
                        r_index <= w_victim;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    for (int i = 0; i < N; i++) begin
                        if (COUNTER_WIDTH'(i) == r_index) begin
                            r_tags[i]  <= r_tag;
                            r_valid[i] <= 1'b1;
                        end
                    end
                    r_resp_hit   <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_enable     <= 1'b1;
                    r_resp_line  <= r_index;
                    r_last_line  <= r_index;
                    r_state      <= RESPOND;
                end
                RESPOND: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_bus.requestReady       = (r_state == IDLE) && !r_flush_pending && !req_bus.invalidate;
    assign req_bus.responseValid      = r_resp_valid;
    assign req_bus.responseHit        = r_resp_hit;
    assign req_bus.responseCacheLine  = r_resp_line;
    assign repl_bus.lastAccessedCacheLine = r_last_line;
    assign repl_bus.enable            = r_enable;
    assign repl_bus.replacementReset  = reset || w_flush;

endmodule
